// File: rtl/vending_pkg.sv
// Shared types and coin helpers for the parametrised vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCredit,
    StVend,
    StChange
  } state_e;

  localparam logic [1:0] Coin1  = 2'd0;
  localparam logic [1:0] Coin2  = 2'd1;
  localparam logic [1:0] Coin5  = 2'd2;
  localparam logic [1:0] Coin10 = 2'd3;

  function automatic logic [3:0] coin_value(input logic [1:0] code);
    unique case (code)
      Coin1:   coin_value = 4'd1;
      Coin2:   coin_value = 4'd2;
      Coin5:   coin_value = 4'd5;
      default: coin_value = 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/vending_fsm_param_change_picker.sv
// Picks the largest coin denomination that still fits in the remaining credit.
module change_picker
  import vending_pkg::*;
#(
  parameter int unsigned CW = 7
) (
  input  logic [CW-1:0] credit,
  output logic [1:0]    code,
  output logic          valid
);

  always_comb begin
    code  = Coin1;
    valid = (credit != '0);
    if (credit >= CW'(coin_value(Coin10))) begin
      code = Coin10;
    end else if (credit >= CW'(coin_value(Coin5))) begin
      code = Coin5;
    end else if (credit >= CW'(coin_value(Coin2))) begin
      code = Coin2;
    end
  end

endmodule

// File: rtl/vending_fsm_param.sv
// Parametrised vending controller: credit accumulation, product vend and
// coin-by-coin change payout, all advanced by the tick strobe.
module vending_fsm_param
  import vending_pkg::*;
#(
  parameter int unsigned N_PROD = 4,
  parameter int unsigned CW = 7,
  parameter logic [N_PROD*CW-1:0] PRICES = {7'd15, 7'd10, 7'd7, 7'd5},
  parameter int unsigned TIMEOUT = 1000,
  localparam int unsigned PW = $clog2(N_PROD)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          coin_valid,
  input  logic [1:0]    coin_code,
  input  logic          sel_valid,
  input  logic [PW-1:0] sel,
  input  logic          cancel,
  output logic          vend,
  output logic [PW-1:0] vend_id,
  output logic          chg_valid,
  output logic [1:0]    chg_code,
  input  logic          chg_ready,
  output logic [CW-1:0] credit,
  output logic          busy,
  output logic          err_price
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [PW-1:0] vend_id_q, vend_id_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          vend_q, vend_d;
  logic          err_q, err_d;
  logic          chg_valid_q, chg_valid_d;
  logic [1:0]    chg_code_q, chg_code_d;
  logic          busy_q, busy_d;

  logic [3:0]    coin_amt;
  logic [CW:0]   sum_w;
  logic [CW-1:0] credit_sum;
  logic          sel_ok;
  logic [PW-1:0] sel_idx;
  logic [CW-1:0] price;
  logic          sel_accept;
  logic          timeout;
  logic [CW-1:0] chg_amt;
  logic          chg_fire;
  logic [1:0]    pick_code;
  logic          pick_valid;

  // Coins are credited before cancel/sel are evaluated; overflow saturates.
  assign coin_amt   = coin_valid ? coin_value(coin_code) : 4'd0;
  assign sum_w      = {1'b0, credit_q} + (CW + 1)'(coin_amt);
  assign credit_sum = sum_w[CW] ? '1 : sum_w[CW-1:0];

  assign sel_ok     = (32'(sel) < N_PROD);
  assign sel_idx    = sel_ok ? sel : '0;
  assign price      = PRICES[32'(sel_idx) * CW +: CW];
  assign sel_accept = sel_ok && (credit_sum >= price);

  assign timeout    = !coin_valid && (tmr_q == TW'(TIMEOUT - 1));
  assign chg_amt    = CW'(coin_value(chg_code_q));
  assign chg_fire   = (state_q == StChange) && chg_valid_q && chg_ready;

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    vend_id_d = vend_id_q;
    tmr_d     = tmr_q;
    vend_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (coin_valid) begin
          credit_d = credit_sum;
          tmr_d    = '0;
          state_d  = StCredit;
        end
      end
      StCredit: begin
        credit_d = credit_sum;
        tmr_d    = coin_valid ? '0 : tmr_q + TW'(1);
        if (cancel) begin
          state_d = StChange;
        end else if (sel_valid && sel_accept) begin
          credit_d  = credit_sum - price;
          vend_id_d = sel;
          vend_d    = 1'b1;
          state_d   = StVend;
        end else begin
          err_d = sel_valid;
          if (timeout) begin
            state_d = StChange;
          end
        end
      end
      StVend: begin
        state_d = (credit_q != '0) ? StChange : StIdle;
      end
      StChange: begin
        if (chg_fire) begin
          credit_d = credit_q - chg_amt;
          if (credit_d == '0) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  change_picker #(
    .CW(CW)
  ) u_picker (
    .credit(credit_d),
    .code  (pick_code),
    .valid (pick_valid)
  );

  // Change outputs are precomputed from the next credit so they are registered.
  assign chg_valid_d = (state_d == StChange) && pick_valid;
  assign chg_code_d  = pick_code;
  assign busy_d      = (state_d == StVend) || (state_d == StChange);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      credit_q    <= '0;
      vend_id_q   <= '0;
      tmr_q       <= '0;
      vend_q      <= 1'b0;
      err_q       <= 1'b0;
      chg_valid_q <= 1'b0;
      chg_code_q  <= 2'd0;
      busy_q      <= 1'b0;
    end else if (tick) begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      vend_id_q   <= vend_id_d;
      tmr_q       <= tmr_d;
      vend_q      <= vend_d;
      err_q       <= err_d;
      chg_valid_q <= chg_valid_d;
      chg_code_q  <= chg_code_d;
      busy_q      <= busy_d;
    end
  end

  assign vend      = vend_q;
  assign vend_id   = vend_id_q;
  assign chg_valid = chg_valid_q;
  assign chg_code  = chg_code_q;
  assign credit    = credit_q;
  assign busy      = busy_q;
  assign err_price = err_q;

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    (tick && chg_fire) |-> (credit_q >= chg_amt));

endmodule

// File: tb/tb_vending_fsm_param.sv
// Directed bench for vending_fsm_param: default instance plus a CW=4 instance
// sharing the same stimulus for the saturation case.
module tb_vending_fsm_param;

  localparam int unsigned TO = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_code = 2'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       cancel = 1'b0;
  logic       chg_ready = 1'b0;

  logic       vend, chg_valid, busy, err_price;
  logic [1:0] vend_id, chg_code;
  logic [6:0] credit;

  logic       vend4, chg_valid4, busy4, err4;
  logic [1:0] vend_id4, chg_code4;
  logic [3:0] credit4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vending_fsm_param dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .coin_valid(coin_valid),
    .coin_code (coin_code),
    .sel_valid (sel_valid),
    .sel       (sel),
    .cancel    (cancel),
    .vend      (vend),
    .vend_id   (vend_id),
    .chg_valid (chg_valid),
    .chg_code  (chg_code),
    .chg_ready (chg_ready),
    .credit    (credit),
    .busy      (busy),
    .err_price (err_price)
  );

  vending_fsm_param #(
    .N_PROD (4),
    .CW     (4),
    .PRICES ({4'd15, 4'd10, 4'd7, 4'd5}),
    .TIMEOUT(TO)
  ) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .coin_valid(coin_valid),
    .coin_code (coin_code),
    .sel_valid (sel_valid),
    .sel       (sel),
    .cancel    (cancel),
    .vend      (vend4),
    .vend_id   (vend_id4),
    .chg_valid (chg_valid4),
    .chg_code  (chg_code4),
    .chg_ready (chg_ready),
    .credit    (credit4),
    .busy      (busy4),
    .err_price (err4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] c);
    coin_valid = 1'b1;
    coin_code  = c;
    cyc();
    coin_valid = 1'b0;
  endtask

  task automatic pick(input logic [1:0] s);
    sel_valid = 1'b1;
    sel       = s;
    cyc();
    sel_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    cyc();
    cyc();
    check_eq("rst_vend", vend, 0);
    check_eq("rst_chg_valid", chg_valid, 0);
    check_eq("rst_credit", credit, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err_price, 0);
    rst_n = 1'b1;
    cyc();

    // 10+5, product 3 (price 15): exact-price vend, no change
    put_coin(2'd3);
    check_eq("t1_credit10", credit, 10);
    put_coin(2'd2);
    check_eq("t1_credit15", credit, 15);
    pick(2'd3);
    check_eq("t1_vend", vend, 1);
    check_eq("t1_vend_id", vend_id, 3);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_credit0", credit, 0);
    cyc();
    check_eq("t1_vend_off", vend, 0);
    check_eq("t1_no_chg", chg_valid, 0);
    check_eq("t1_idle", busy, 0);

    // 10+10, product 2 (price 10 at index 2): one 10-unit change coin
    put_coin(2'd3);
    put_coin(2'd3);
    check_eq("t2_credit20", credit, 20);
    pick(2'd2);
    check_eq("t2_vend_id", vend_id, 2);
    check_eq("t2_credit10", credit, 10);
    check_eq("t2_chg_in_vend", chg_valid, 0);
    cyc();
    check_eq("t2_chg_valid", chg_valid, 1);
    check_eq("t2_chg_code", chg_code, 3);
    chg_ready = 1'b1;
    cyc();
    chg_ready = 1'b0;
    check_eq("t2_credit0", credit, 0);
    check_eq("t2_chg_done", chg_valid, 0);
    check_eq("t2_idle", busy, 0);

    // 5, product 1 (price 7): rejected, then cancel refunds a 5
    put_coin(2'd2);
    pick(2'd1);
    check_eq("t3_err", err_price, 1);
    check_eq("t3_credit5", credit, 5);
    check_eq("t3_no_vend", vend, 0);
    cyc();
    check_eq("t3_err_off", err_price, 0);
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    check_eq("t3_chg_valid", chg_valid, 1);
    check_eq("t3_chg_code", chg_code, 2);
    put_coin(2'd3);
    check_eq("t3_coin_ignored", credit, 5);
    chg_ready = 1'b1;
    cyc();
    chg_ready = 1'b0;
    check_eq("t3_credit0", credit, 0);
    check_eq("t3_idle", busy, 0);

    // Coin in the same tick as a selection is counted: 2 + 5 >= 5
    put_coin(2'd1);
    coin_valid = 1'b1;
    coin_code  = 2'd2;
    pick(2'd0);
    coin_valid = 1'b0;
    check_eq("t4_vend", vend, 1);
    check_eq("t4_vend_id", vend_id, 0);
    check_eq("t4_credit2", credit, 2);
    cyc();
    check_eq("t4_chg_code", chg_code, 1);
    chg_ready = 1'b1;
    cyc();
    chg_ready = 1'b0;
    check_eq("t4_credit0", credit, 0);

    // Tick low freezes the FSM
    tick = 1'b0;
    coin_valid = 1'b1;
    coin_code  = 2'd3;
    cyc();
    cyc();
    cyc();
    coin_valid = 1'b0;
    tick = 1'b1;
    check_eq("t5_tick_gate", credit, 0);

    // Timeout: 1 unit, refund after exactly TO idle ticks, hopper stall
    put_coin(2'd0);
    for (int i = 0; i < TO - 1; i++) cyc();
    check_eq("t6_before_to", chg_valid, 0);
    cyc();
    check_eq("t6_to_valid", chg_valid, 1);
    check_eq("t6_to_code", chg_code, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_eq("t6_hold_valid", chg_valid, 1);
      check_eq("t6_hold_code", chg_code, 0);
    end
    chg_ready = 1'b1;
    cyc();
    chg_ready = 1'b0;
    check_eq("t6_credit0", credit, 0);
    check_eq("t6_chg_done", chg_valid, 0);

    // CW=4 saturation: 10+10 clamps to 15, refund 10 then 5
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    put_coin(2'd3);
    put_coin(2'd3);
    check_eq("t7_sat", credit4, 15);
    check_eq("t7_wide", credit, 20);
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    check_eq("t7_code10", chg_code4, 3);
    chg_ready = 1'b1;
    cyc();
    check_eq("t7_credit5", credit4, 5);
    check_eq("t7_code5", chg_code4, 2);
    check_eq("t7_valid5", chg_valid4, 1);
    cyc();
    chg_ready = 1'b0;
    check_eq("t7_credit0", credit4, 0);
    check_eq("t7_done", chg_valid4, 0);

    // Asynchronous reset in the middle of a payout
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    put_coin(2'd3);
    put_coin(2'd2);
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    check_eq("t8_in_change", chg_valid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t8_rst_valid", chg_valid, 0);
    check_eq("t8_rst_credit", credit, 0);
    check_eq("t8_rst_busy", busy, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check_eq("t8_idle_credit", credit, 0);
    check_eq("t8_idle_valid", chg_valid, 0);
    put_coin(2'd1);
    check_eq("t8_new_coin", credit, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
